bram_reader: RTL
================

# bram_reader

Sequential read-side engine for the 48-bit × 1024-word dual-port BRAM. It is the consumer counterpart of the BRAM write FSM. On `start` it sweeps a programmable address range through one BRAM port with `we` held low. It absorbs the BRAM's one-cycle registered read latency with a 2-entry output buffer and streams the words out over a valid/ready interface at up to one word per cycle.

## Interface
- `DATA_W`, 48, BRAM word width
- `ADDR_W`, 10, BRAM address width (depth 2^ADDR_W)

- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high; clears all state
- `start` input 1: begin a sweep; sampled only when `busy`=0
- `base_addr` input ADDR_W: first address, sampled with `start`
- `count` input ADDR_W+1: number of words, 0..1024, sampled with `start`
- `busy` output 1: sweep in progress
- `done` output 1: one-cycle pulse when the last word has been accepted
- `bram_addr` output ADDR_W: registered read address to the BRAM port
- `bram_we` output 1: constant 0
- `bram_q` input DATA_W: BRAM read data, valid one cycle after the address edge
- `out_data` output DATA_W: head word of the output buffer
- `out_valid` output 1: `out_data` is valid
- `out_ready` input 1: consumer accepts `out_data` when `out_valid`&&`out_ready`
- `z` output 7: seven-segment pattern, active-high segments {g..a}; present only with `BRAM_READER_HEX_EN`

## Operation
- State machine states:
  - IDLE: wait for `start`.
  - READ: issue reads.
  - DRAIN: all reads issued; wait until the buffer and the in-flight slot are empty.
- IDLE→READ on `start` with `count`≠0. Latch `base_addr` into the address register and `count` into the remaining-issue counter.
- IDLE with `start` and `count`=0: no reads. `done` pulses on the next cycle and `busy` stays 0.
- `start` while `busy`=1 is ignored.
- Issue rule:
  - In READ, a read is issued in a cycle when `occupancy + inflight - pop < 2`.
  - `pop` = `out_valid`&&`out_ready`.
  - `inflight` = a read was issued in the previous cycle.
  - On issue, the address increments modulo 2^ADDR_W (wrap 1023→0) and the remaining counter decrements.
- READ→DRAIN when the remaining counter reaches 0.
- DRAIN→IDLE on the edge where the final word is popped. `done`=1 for the following cycle.
- `bram_q` is written into the buffer on the edge after each issue edge.
- Words leave in strict address order; none are dropped or duplicated.
- Buffer full and no pop: no issue. Writing into the buffer and popping in the same cycle is legal; occupancy is unchanged.
- `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-sweep:
  - State returns to IDLE and the buffer empties.
  - The in-flight read is discarded.
  - No `done` pulse.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `out_valid`=0.
  - `bram_addr`=0, `out_data`=0, `bram_we`=0.
  - `z` shows blank (7'b0000000).
- Edge k samples `start`. Then `busy`=1 and `bram_addr`=`base_addr` after edge k.
- Edge k+1: the BRAM registers the read.
- Edge k+2: the buffer captures the word and `out_valid`=1. Start-to-first-valid latency is 2 cycles.
- With `out_ready` held high, words are delivered one per cycle. A sweep of N words ends with `done` N+2 cycles after edge k.
- `done` and `busy`→0 occur together, one cycle after the last pop.

## Configuration
- `BRAM_READER_HEX_EN` defined:
  - Adds output `z`.
  - It is a registered hex decode of `out_data[3:0]` of the most recently popped word, with the standard 0-F glyphs.
  - It updates on each pop and holds otherwise.
- Not defined: port `z` and its decode logic are absent. All other behaviour is identical.

## Test plan
- BRAM preloaded with word[i]=i. Inputs: `start`, `base_addr`=0, `count`=4, `out_ready`=1. Required: `out_data` 0,1,2,3 on 4 consecutive cycles starting 2 cycles after start, then a `done` pulse, `busy`=0.
- `base_addr`=1022, `count`=4. Required: read addresses 1022,1023,0,1 in that order.
- `count`=4 with `out_ready` held low for 6 cycles after start. Required: at most 2 words buffered, the address stops advancing, `out_data`=word[base] stays stable. After release, all 4 words arrive in order.
- `count`=0. Required: no `bram_addr` change, `done` pulses one cycle after start, `out_valid` stays 0.
- `reset` asserted mid-sweep after 2 of 8 words are popped. Required: all outputs at reset values immediately, no `done`. A new sweep then runs cleanly from its own `base_addr`.
- With `BRAM_READER_HEX_EN` and word=0x...A popped: required `z`=7'b1110111.

Source files
------------

// File: rtl/bram_reader.sv
`timescale 1ns/1ps
// bram_reader: sequential read-side engine for a dual-port BRAM.
// On start it sweeps count words from base_addr through one BRAM port,
// absorbs the BRAM's one-cycle registered read latency with a 2-entry
// output buffer, and streams words out over a valid/ready interface.
//
// Optional feature macro: BRAM_READER_HEX_EN adds a registered seven-segment
// decode (z) of the low nibble of the most recently popped word.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   start, base_addr, count sweep request (sampled only while idle)
//   busy, done             sweep in progress; one-cycle completion pulse
//   bram_addr, bram_we     BRAM read port controls (we is always 0)
//   bram_q                 BRAM read data, one cycle after the address edge
//   out_data, out_valid    head of the output buffer
//   out_ready              consumer accept
//   z                      seven-segment {g..a}, only with BRAM_READER_HEX_EN
module bram_reader #(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef BRAM_READER_HEX_EN
  ,
  output logic [6:0]        z
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                inflight_q, inflight_d;
  logic                vld0_q, vld0_d;
  logic                vld1_q, vld1_d;
  logic [DATA_W-1:0]   buf0_q, buf0_d;
  logic [DATA_W-1:0]   buf1_q, buf1_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                pop;
  logic                push;
  logic                issue;
  logic [1:0]          occ_sum;

`ifdef BRAM_READER_HEX_EN
  logic [6:0]          z_q, z_d;

  // Standard 0-F glyphs, active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction
`endif

  // Buffer accounting: a read issued last cycle lands in the buffer this edge
  assign pop     = vld0_q && out_ready;
  assign push    = inflight_q;
  assign occ_sum = 2'(vld0_q) + 2'(vld1_q) + 2'(inflight_q);
  // occupancy + inflight - pop < 2, rearranged to avoid negative arithmetic
  assign issue   = (state_q == READ) && (pop ? (occ_sum < 2'd3) : (occ_sum < 2'd2));

  // Next-state, sweep control and buffer update
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = issue;
    vld0_d     = vld0_q;
    vld1_d     = vld1_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef BRAM_READER_HEX_EN
    z_d        = z_q;
    if (pop) begin
      z_d = hex7(buf0_q[3:0]);
    end
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != CNT_W'(0)) begin
            state_d = READ;
            addr_d  = base_addr;
            rem_d   = count;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d = ADDR_W'(addr_q + 1'b1);
          rem_d  = CNT_W'(rem_q - 1'b1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Final word: popping the only buffered word with nothing in flight
        if (pop && !vld1_q && !inflight_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Two-entry shift buffer; entry 0 is always the head
    case ({push, pop})
      2'b10: begin
        if (!vld0_q) begin
          buf0_d = bram_q;
          vld0_d = 1'b1;
        end else begin
          buf1_d = bram_q;
          vld1_d = 1'b1;
        end
      end
      2'b01: begin
        if (vld1_q) begin
          buf0_d = buf1_q;
        end
        vld0_d = vld1_q;
        vld1_d = 1'b0;
      end
      2'b11: begin
        if (vld1_q) begin
          buf0_d = buf1_q;
          buf1_d = bram_q;
        end else begin
          buf0_d = bram_q;
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      vld0_q     <= 1'b0;
      vld1_q     <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BRAM_READER_HEX_EN
      z_q        <= 7'b0000000;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      vld0_q     <= vld0_d;
      vld1_q     <= vld1_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BRAM_READER_HEX_EN
      z_q        <= z_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bram_addr = addr_q;
  assign bram_we   = 1'b0;
  assign out_data  = buf0_q;
  assign out_valid = vld0_q;
`ifdef BRAM_READER_HEX_EN
  assign z         = z_q;
`endif

endmodule
